// File: rtl/sw_pe_stream_if.sv
// Stream link between neighbouring Smith-Waterman PEs: one reference beat
// (valid/base/last) travelling together with the score H of the sending PE.
interface sw_pe_stream_if #(
  parameter int SCORE_W = 16
);
  logic               valid;
  logic [1:0]         base;
  logic               last;
  logic [SCORE_W-1:0] h;

  modport master (output valid, base, last, h);
  modport slave  (input  valid, base, last, h);
endinterface

// File: rtl/sw_pe_stream.sv
// Smith-Waterman processing element for a systolic array: one read base per
// PE, one anti-diagonal cell per accepted reference beat, saturating scores.
// Optional best-cell tracker (max_o / max_pos_o and the column counter) is
// built only when SW_PE_MAXTRACK_EN is defined; otherwise both read 0.
module sw_pe_stream #(
  parameter int SCORE_W = 16,
  parameter int PEN_W   = 4,
  parameter int POS_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               load_i,
  input  logic [1:0]         read_base_i,
  sw_pe_stream_if.slave      up,
  sw_pe_stream_if.master     dn,
  input  logic [PEN_W-1:0]   match_i,
  input  logic [PEN_W-1:0]   mismatch_i,
  input  logic [PEN_W-1:0]   gap_i,
  output logic [SCORE_W-1:0] max_o,
  output logic [POS_W-1:0]   max_pos_o,
  output logic               done_o
);

  localparam int EXT_W = SCORE_W + 1;
  typedef logic [EXT_W-1:0] ext_t;
  localparam ext_t SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  // One extra bit of headroom lets the sum be checked against the ceiling.
  function automatic ext_t sat_add(input ext_t a, input ext_t b);
    ext_t s;
    s = a + b;
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

  // Scores are unsigned, so a subtraction bottoms out at zero.
  function automatic ext_t sub_clamp(input ext_t a, input ext_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

  logic [1:0]         read_q, read_d;
  logic [SCORE_W-1:0] diag_q, diag_d;
  logic [SCORE_W-1:0] h_q, h_d;
  logic               valid_q, valid_d;
  logic [1:0]         ref_q, ref_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  ext_t               diag_base;
  ext_t               left_base;
  ext_t               diag_term;
  ext_t               up_term;
  ext_t               left_term;
  ext_t               cand;
  logic [SCORE_W-1:0] cand_score;

  // Cell score: a start in the same cycle makes the beat see cleared diag/left.
  always_comb begin
    diag_base = start_i ? '0 : ext_t'(diag_q);
    left_base = start_i ? '0 : ext_t'(h_q);
    if (up.base == read_q) begin
      diag_term = sat_add(diag_base, ext_t'(match_i));
    end else begin
      diag_term = sub_clamp(diag_base, ext_t'(mismatch_i));
    end
    up_term   = sub_clamp(ext_t'(up.h), ext_t'(gap_i));
    left_term = sub_clamp(left_base, ext_t'(gap_i));
    cand = diag_term;
    if (up_term > cand) begin
      cand = up_term;
    end
    if (left_term > cand) begin
      cand = left_term;
    end
    cand_score = (cand > SCORE_MAX) ? {SCORE_W{1'b1}} : cand[SCORE_W-1:0];
  end

  // Datapath next state: forward the beat and keep the neighbours' scores.
  always_comb begin
    read_d  = load_i ? read_base_i : read_q;
    diag_d  = start_i ? '0 : diag_q;
    h_d     = start_i ? '0 : h_q;
    ref_d   = ref_q;
    last_d  = last_q;
    valid_d = up.valid;
    done_d  = up.valid & up.last;
    if (up.valid) begin
      h_d    = cand_score;
      diag_d = up.h;
      ref_d  = up.base;
      last_d = up.last;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_q  <= '0;
      diag_q  <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
      ref_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      read_q  <= read_d;
      diag_q  <= diag_d;
      h_q     <= h_d;
      valid_q <= valid_d;
      ref_q   <= ref_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef SW_PE_MAXTRACK_EN
  logic [SCORE_W-1:0] max_q, max_d, max_base;
  logic [POS_W-1:0]   max_pos_q, max_pos_d;
  logic [POS_W-1:0]   col_q, col_d, col_base;

  // Best-cell tracker: strict compare so a tie keeps the earliest column.
  always_comb begin
    max_base  = start_i ? '0 : max_q;
    col_base  = start_i ? '0 : col_q;
    max_d     = max_base;
    max_pos_d = start_i ? '0 : max_pos_q;
    col_d     = col_base;
    if (up.valid) begin
      col_d = (&col_base) ? col_base : col_base + POS_W'(1);
      if (cand_score > max_base) begin
        max_d     = cand_score;
        max_pos_d = col_base;
      end
    end
  end

  // Tracker registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q     <= '0;
      max_pos_q <= '0;
      col_q     <= '0;
    end else begin
      max_q     <= max_d;
      max_pos_q <= max_pos_d;
      col_q     <= col_d;
    end
  end

  assign max_o     = max_q;
  assign max_pos_o = max_pos_q;
`else
  assign max_o     = '0;
  assign max_pos_o = '0;
`endif

  assign dn.valid = valid_q;
  assign dn.base  = ref_q;
  assign dn.last  = last_q;
  assign dn.h     = h_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_sw_pe_stream.sv
// Self-checking bench for sw_pe_stream: directed vector table, saturation on an
// 8-bit PE, a 4-PE chain, randomized beats against an arithmetic model, and an
// asynchronous reset in the middle of a stream.
module tb_sw_pe_stream;

  localparam int SW   = 16;
  localparam int PW   = 4;
  localparam int QW   = 12;
  localparam int SMAX = 65535;
  localparam int CMAX = 4095;
`ifdef SW_PE_MAXTRACK_EN
  localparam bit MT = 1'b1;
`else
  localparam bit MT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT A: default widths, used for the table, random and reset tests.
  logic          a_start, a_load;
  logic [1:0]    a_rb;
  logic [PW-1:0] a_match, a_mm, a_gap;
  logic [SW-1:0] a_max;
  logic [QW-1:0] a_pos;
  logic          a_done;
  sw_pe_stream_if #(.SCORE_W(SW)) a_up ();
  sw_pe_stream_if #(.SCORE_W(SW)) a_dn ();

  sw_pe_stream #(.SCORE_W(SW), .PEN_W(PW), .POS_W(QW)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .load_i(a_load), .read_base_i(a_rb),
    .up(a_up), .dn(a_dn), .match_i(a_match), .mismatch_i(a_mm), .gap_i(a_gap),
    .max_o(a_max), .max_pos_o(a_pos), .done_o(a_done));

  // DUT B: 8-bit scores for the saturation case.
  logic          b_start, b_load;
  logic [1:0]    b_rb;
  logic [PW-1:0] b_match, b_mm, b_gap;
  logic [7:0]    b_max;
  logic [QW-1:0] b_pos;
  logic          b_done;
  sw_pe_stream_if #(.SCORE_W(8)) b_up ();
  sw_pe_stream_if #(.SCORE_W(8)) b_dn ();

  sw_pe_stream #(.SCORE_W(8), .PEN_W(PW), .POS_W(QW)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .load_i(b_load), .read_base_i(b_rb),
    .up(b_up), .dn(b_dn), .match_i(b_match), .mismatch_i(b_mm), .gap_i(b_gap),
    .max_o(b_max), .max_pos_o(b_pos), .done_o(b_done));

  // Chain C: four PEs, one per read base.
  logic          c_start, c_load;
  logic [1:0]    c_rb [4];
  logic [PW-1:0] c_match, c_mm, c_gap;
  logic [SW-1:0] c_max [4];
  logic [QW-1:0] c_pos [4];
  logic          c_done [4];
  sw_pe_stream_if #(.SCORE_W(SW)) c_if0 ();
  sw_pe_stream_if #(.SCORE_W(SW)) c_if1 ();
  sw_pe_stream_if #(.SCORE_W(SW)) c_if2 ();
  sw_pe_stream_if #(.SCORE_W(SW)) c_if3 ();
  sw_pe_stream_if #(.SCORE_W(SW)) c_if4 ();

  sw_pe_stream #(.SCORE_W(SW), .PEN_W(PW), .POS_W(QW)) pe0 (
    .clk(clk), .rst(rst), .start_i(c_start), .load_i(c_load), .read_base_i(c_rb[0]),
    .up(c_if0), .dn(c_if1), .match_i(c_match), .mismatch_i(c_mm), .gap_i(c_gap),
    .max_o(c_max[0]), .max_pos_o(c_pos[0]), .done_o(c_done[0]));
  sw_pe_stream #(.SCORE_W(SW), .PEN_W(PW), .POS_W(QW)) pe1 (
    .clk(clk), .rst(rst), .start_i(c_start), .load_i(c_load), .read_base_i(c_rb[1]),
    .up(c_if1), .dn(c_if2), .match_i(c_match), .mismatch_i(c_mm), .gap_i(c_gap),
    .max_o(c_max[1]), .max_pos_o(c_pos[1]), .done_o(c_done[1]));
  sw_pe_stream #(.SCORE_W(SW), .PEN_W(PW), .POS_W(QW)) pe2 (
    .clk(clk), .rst(rst), .start_i(c_start), .load_i(c_load), .read_base_i(c_rb[2]),
    .up(c_if2), .dn(c_if3), .match_i(c_match), .mismatch_i(c_mm), .gap_i(c_gap),
    .max_o(c_max[2]), .max_pos_o(c_pos[2]), .done_o(c_done[2]));
  sw_pe_stream #(.SCORE_W(SW), .PEN_W(PW), .POS_W(QW)) pe3 (
    .clk(clk), .rst(rst), .start_i(c_start), .load_i(c_load), .read_base_i(c_rb[3]),
    .up(c_if3), .dn(c_if4), .match_i(c_match), .mismatch_i(c_mm), .gap_i(c_gap),
    .max_o(c_max[3]), .max_pos_o(c_pos[3]), .done_o(c_done[3]));

  // Directed vector: inputs for one cycle and the outputs expected after it.
  typedef struct {
    int start; int load; int rb; int valid; int rf; int last; int hin;
    int eh; int emax; int epos; int ev; int ed;
  } vec_t;
  vec_t tbl [12];

  // Reference model state for DUT A.
  int m_read, m_diag, m_h, m_col, m_max, m_pos, m_valid, m_ref, m_last, m_done;

  function automatic int exp_mt(input int v);
    return MT ? v : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_start    = v.start[0];
    a_load     = v.load[0];
    a_rb       = v.rb[1:0];
    a_up.valid = v.valid[0];
    a_up.base  = v.rf[1:0];
    a_up.last  = v.last[0];
    a_up.h     = v.hin[15:0];
  endtask

  // Model: one clock of the alignment rules, using A's current inputs.
  task automatic modelClock();
    int sd, ut, lt, cand;
    if (a_start) begin
      m_h = 0; m_diag = 0; m_col = 0; m_max = 0; m_pos = 0;
    end
    if (a_up.valid) begin
      if (int'(a_up.base) == m_read) begin
        sd = m_diag + int'(a_match);
        if (sd > SMAX) sd = SMAX;
      end else begin
        sd = m_diag - int'(a_mm);
        if (sd < 0) sd = 0;
      end
      ut = int'(a_up.h) - int'(a_gap);
      if (ut < 0) ut = 0;
      lt = m_h - int'(a_gap);
      if (lt < 0) lt = 0;
      cand = sd;
      if (ut > cand) cand = ut;
      if (lt > cand) cand = lt;
      if (cand > m_max) begin
        m_max = cand;
        m_pos = m_col;
      end
      if (m_col < CMAX) m_col++;
      m_h = cand;
      m_diag = int'(a_up.h);
      m_ref = int'(a_up.base);
      m_last = int'(a_up.last);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    m_done = (a_up.valid && a_up.last) ? 1 : 0;
    if (a_load) m_read = int'(a_rb);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".h"},     64'(a_dn.h),     64'(m_h));
    checkOutput({tag, ".valid"}, 64'(a_dn.valid), 64'(m_valid));
    checkOutput({tag, ".ref"},   64'(a_dn.base),  64'(m_ref));
    checkOutput({tag, ".last"},  64'(a_dn.last),  64'(m_last));
    checkOutput({tag, ".done"},  64'(a_done),     64'(m_done));
    checkOutput({tag, ".max"},   64'(a_max),      64'(exp_mt(m_max)));
    checkOutput({tag, ".pos"},   64'(a_pos),      64'(exp_mt(m_pos)));
  endtask

  initial begin
    int row4 [4];
    row4 = '{0, 2, 5, 8};

    rst = 1'b1;
    a_start = 1'b0; a_load = 1'b0; a_rb = 2'd0;
    a_up.valid = 1'b0; a_up.base = 2'd0; a_up.last = 1'b0; a_up.h = '0;
    a_match = 4'd2; a_mm = 4'd1; a_gap = 4'd1;
    b_start = 1'b0; b_load = 1'b0; b_rb = 2'd0;
    b_up.valid = 1'b0; b_up.base = 2'd0; b_up.last = 1'b0; b_up.h = '0;
    b_match = 4'd3; b_mm = 4'd1; b_gap = 4'd1;
    c_start = 1'b0; c_load = 1'b0;
    for (int k = 0; k < 4; k++) c_rb[k] = 2'(k);
    c_if0.valid = 1'b0; c_if0.base = 2'd0; c_if0.last = 1'b0; c_if0.h = '0;
    c_match = 4'd2; c_mm = 4'd1; c_gap = 4'd1;

    // start, load, rb, valid, ref, last, h_i | h, max, pos, valid_o, done_o
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 0,  2, 2, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 1, 0, 0,  1, 2, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 1, 0,  2, 2, 0, 1, 1};
    tbl[4]  = '{1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 5,  4, 4, 1, 1, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 0,  2, 2, 0, 1, 0};
    tbl[7]  = '{0, 1, 1, 1, 0, 0, 0,  2, 2, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 0, 0,  2, 2, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 0, 0, 7,  6, 6, 3, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 2, 1, 9,  6, 6, 3, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 2, 1, 0,  6, 6, 3, 1, 1};

    #12;
    checkOutput("reset.h",     64'(a_dn.h),     64'(0));
    checkOutput("reset.valid", 64'(a_dn.valid), 64'(0));
    checkOutput("reset.ref",   64'(a_dn.base),  64'(0));
    checkOutput("reset.last",  64'(a_dn.last),  64'(0));
    checkOutput("reset.max",   64'(a_max),      64'(0));
    checkOutput("reset.pos",   64'(a_pos),      64'(0));
    checkOutput("reset.done",  64'(a_done),     64'(0));
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput($sformatf("vec%0d.h", i),     64'(a_dn.h),     64'(tbl[i].eh));
      checkOutput($sformatf("vec%0d.max", i),   64'(a_max),      64'(exp_mt(tbl[i].emax)));
      checkOutput($sformatf("vec%0d.pos", i),   64'(a_pos),      64'(exp_mt(tbl[i].epos)));
      checkOutput($sformatf("vec%0d.valid", i), 64'(a_dn.valid), 64'(tbl[i].ev));
      checkOutput($sformatf("vec%0d.done", i),  64'(a_done),     64'(tbl[i].ed));
    end
    a_start = 1'b0; a_load = 1'b0; a_up.valid = 1'b0; a_up.last = 1'b0;

    $display("[TB] 8-bit saturation");
    b_start = 1'b1; b_load = 1'b1; b_rb = 2'd0;
    tick();
    b_start = 1'b0; b_load = 1'b0;
    b_up.valid = 1'b1; b_up.base = 2'd0; b_up.h = 8'd254;
    tick();
    checkOutput("sat.first_h", 64'(b_dn.h), 64'(253));
    b_up.h = 8'd0; b_up.last = 1'b1;
    tick();
    checkOutput("sat.second_h", 64'(b_dn.h),  64'(255));
    checkOutput("sat.max",      64'(b_max),   64'(exp_mt(255)));
    checkOutput("sat.pos",      64'(b_pos),   64'(exp_mt(1)));
    checkOutput("sat.done",     64'(b_done),  64'(1));
    b_up.last = 1'b0;
    tick();
    checkOutput("sat.third_h", 64'(b_dn.h), 64'(254));
    b_up.valid = 1'b0;

    $display("[TB] four-PE chain");
    c_start = 1'b1; c_load = 1'b1;
    tick();
    c_start = 1'b0; c_load = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      if (e <= 4) begin
        c_if0.valid = 1'b1;
        c_if0.base  = 2'(e - 1);
        c_if0.last  = (e == 4);
      end else begin
        c_if0.valid = 1'b0;
        c_if0.last  = 1'b0;
      end
      tick();
      checkOutput($sformatf("chain.valid@%0d", e), 64'(c_if4.valid), 64'((e >= 4) ? 1 : 0));
      checkOutput($sformatf("chain.h@%0d", e),     64'(c_if4.h),     64'((e >= 4) ? row4[e-4] : 0));
      checkOutput($sformatf("chain.done@%0d", e),  64'(c_done[3]),   64'((e == 7) ? 1 : 0));
    end
    checkOutput("chain.max", 64'(c_max[3]), 64'(exp_mt(8)));
    checkOutput("chain.pos", 64'(c_pos[3]), 64'(exp_mt(3)));
    checkOutput("chain.last", 64'(c_if4.last), 64'(1));

    $display("[TB] randomized beats against model");
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_read = 0; m_diag = 0; m_h = 0; m_col = 0; m_max = 0; m_pos = 0;
    m_valid = 0; m_ref = 0; m_last = 0; m_done = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) begin
        a_match = 4'($urandom_range(0, 15));
        a_mm    = 4'($urandom_range(0, 15));
        a_gap   = 4'($urandom_range(0, 15));
      end
      a_start    = ($urandom_range(0, 15) == 0);
      a_load     = ($urandom_range(0, 7) == 0);
      a_rb       = 2'($urandom_range(0, 3));
      a_up.valid = ($urandom_range(0, 3) != 0);
      a_up.base  = 2'($urandom_range(0, 3));
      a_up.last  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) a_up.h = 16'($urandom_range(65500, 65535));
      else                           a_up.h = 16'($urandom_range(0, 60));
      modelClock();
      tick();
      checkModel($sformatf("rand%0d", n));
    end

    $display("[TB] asynchronous reset mid-stream");
    a_start = 1'b0; a_load = 1'b0;
    a_match = 4'd2; a_mm = 4'd1; a_gap = 4'd1;
    a_up.valid = 1'b1; a_up.last = 1'b0; a_up.base = 2'd1; a_up.h = 16'd30;
    modelClock();
    tick();
    checkModel("prerst");
    a_up.last = 1'b1; a_up.h = 16'd40;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst.h",     64'(a_dn.h),     64'(0));
    checkOutput("rst.valid", 64'(a_dn.valid), 64'(0));
    checkOutput("rst.ref",   64'(a_dn.base),  64'(0));
    checkOutput("rst.last",  64'(a_dn.last),  64'(0));
    checkOutput("rst.max",   64'(a_max),      64'(0));
    checkOutput("rst.pos",   64'(a_pos),      64'(0));
    checkOutput("rst.done",  64'(a_done),     64'(0));
    tick();
    checkOutput("rst.done_after_edge", 64'(a_done), 64'(0));
    checkOutput("rst.h_after_edge",    64'(a_dn.h), 64'(0));
    #3;
    rst = 1'b0;
    a_up.valid = 1'b0; a_up.last = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
